dmem_lsu: RTL and testbench

Load/store unit between the MIPS pipeline's MEM stage and the word-organised data memory. It takes byte-addressed byte, halfword and word requests. It drives the data memory's word-wide read/write port and performs read-modify-write for sub-word stores. It returns aligned, sign- or zero-extended load data through a valid/ready request channel and a one-cycle response pulse.

---
 rtl/lsu_pkg.sv | 25 ++
 rtl/dmem_lsu_lane_align.sv | 41 ++++
 rtl/dmem_lsu.sv | 129 ++++++++++++
 tb/tb_dmem_lsu.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and constants for the data-memory load/store unit.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    RESP
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_BYTE: is_misaligned = 1'b0;
      SZ_HALF: is_misaligned = off[0];
      SZ_WORD: is_misaligned = (off != 2'b00);
      default: is_misaligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lsu_lane_align.sv
// Little-endian lane extraction/extension for loads and lane merge for sub-word stores.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic        sgn,
  output logic [31:0] load_data,
  output logic [31:0] store_data
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b     = word[{off, 3'b000} +: 8];
    lane_h     = off[1] ? word[31:16] : word[15:0];
    load_data  = word;
    store_data = wdata;
    case (size)
      SZ_BYTE: begin
        load_data  = {{24{sgn & lane_b[7]}}, lane_b};
        store_data = word;
        store_data[{off, 3'b000} +: 8] = wdata[7:0];
      end
      SZ_HALF: begin
        load_data  = {{16{sgn & lane_h[15]}}, lane_h};
        store_data = word;
        if (off[1]) store_data[31:16] = wdata[15:0];
        else        store_data[15:0]  = wdata[15:0];
      end
      default: begin
        load_data  = word;
        store_data = wdata;
      end
    endcase
  end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit between MEM stage and word-organised data memory.
// LSU_MISALIGN_TRAP_EN: report misaligned/illegal requests instead of truncating them.
module dmem_lsu
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_misalign,
  output logic [ADDR_W-1:0] mem_raddr,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic              mem_read,
  output logic              mem_write,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  state_t      state, state_nx;
  logic        accept;
  logic        r_we, r_sgn;
  logic [1:0]  r_size, r_off;
  logic [31:0] r_wdata;
  logic [1:0]  a_size, a_off;
  logic        a_mis;
  logic [31:0] load_data, store_data;
  logic        unused_addr;

  assign unused_addr = ^req_addr[31:ADDR_W+2];
  assign req_ready   = (state == IDLE) & ~rst;
  assign accept      = req_valid & req_ready;

  always_comb begin
`ifdef LSU_MISALIGN_TRAP_EN
    a_size = req_size;
    a_off  = req_addr[1:0];
    a_mis  = is_misaligned(req_size, req_addr[1:0]);
`else
    // Illegal size degrades to word; offsets are forced to natural alignment.
    a_size = (req_size == SZ_ILL) ? SZ_WORD : req_size;
    a_mis  = 1'b0;
    case (a_size)
      SZ_HALF: a_off = {req_addr[1], 1'b0};
      SZ_WORD: a_off = 2'b00;
      default: a_off = req_addr[1:0];
    endcase
`endif
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (a_mis)                                state_nx = RESP;
          else if (!req_we || a_size != SZ_WORD)    state_nx = READ;
          else                                      state_nx = WRITE;
        end
      end
      READ:    state_nx = r_we ? WRITE : RESP;
      WRITE:   state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  lsu_lane_align u_align (
    .word       (mem_rdata),
    .wdata      (r_wdata),
    .off        (r_off),
    .size       (r_size),
    .sgn        (r_sgn),
    .load_data  (load_data),
    .store_data (store_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      r_we         <= 1'b0;
      r_sgn        <= 1'b0;
      r_size       <= '0;
      r_off        <= '0;
      r_wdata      <= '0;
      rsp_valid    <= 1'b0;
      rsp_rdata    <= '0;
      rsp_misalign <= 1'b0;
      mem_read     <= 1'b0;
      mem_write    <= 1'b0;
      mem_raddr    <= '0;
      mem_waddr    <= '0;
      mem_wdata    <= '0;
    end else begin
      state     <= state_nx;
      mem_read  <= (state_nx == READ);
      mem_write <= (state_nx == WRITE);
      rsp_valid <= (state_nx == RESP);
      if (accept) begin
        r_we         <= req_we;
        r_sgn        <= req_signed;
        r_size       <= a_size;
        r_off        <= a_off;
        r_wdata      <= req_wdata;
        rsp_rdata    <= '0;
        rsp_misalign <= a_mis;
        if (!a_mis) begin
          if (!req_we || a_size != SZ_WORD) mem_raddr <= req_addr[ADDR_W+1:2];
          if (req_we)                       mem_waddr <= req_addr[ADDR_W+1:2];
          if (req_we && a_size == SZ_WORD)  mem_wdata <= req_wdata;
        end
      end
      // Merged store word is captured straight from the read data.
      if (state == READ) begin
        if (r_we) mem_wdata <= store_data;
        else      rsp_rdata <= load_data;
      end
    end
  end

endmodule

// File: tb/tb_dmem_lsu.sv
// Self-checking bench for dmem_lsu: directed cases plus randomized traffic vs. a behavioural model.
module tb_dmem_lsu;

  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_ready, req_we, req_signed;
  logic [1:0]    req_size;
  logic [31:0]   req_addr, req_wdata;
  logic          rsp_valid, rsp_misalign;
  logic [31:0]   rsp_rdata;
  logic [AW-1:0] mem_raddr, mem_waddr;
  logic          mem_read, mem_write;
  logic [31:0]   mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  dmem_lsu #(.ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_misalign(rsp_misalign),
    .mem_raddr(mem_raddr), .mem_waddr(mem_waddr),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Data memory seen by the DUT, and the model's view of what it must contain.
  logic [31:0] mem     [0:(1<<AW)-1];
  logic [31:0] ref_mem [0:(1<<AW)-1];

  assign mem_rdata = mem_read ? mem[mem_raddr] : 32'hBAD0_BAD0;
  always @(posedge clk) if (mem_write) mem[mem_waddr] <= mem_wdata;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int last_wr_cyc = -1;
  int last_wr_addr = -1;
  always @(posedge clk) if (mem_write) begin
    last_wr_cyc  <= cyc;
    last_wr_addr <= int'(mem_waddr);
  end

  int tests = 0;
  int fails = 0;

  typedef struct {
    int          acc;
    int          due;
    bit          rd;
    int          widx;
    logic [31:0] rdata;
    bit          mis;
  } rsp_t;

  typedef struct {
    int          due;
    int          widx;
    logic [31:0] wdata;
  } wr_t;

  rsp_t rq[$];
  wr_t  wq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Behavioural model: decide latency, response and memory effect at accept time.
  task automatic model_accept(input logic we, input logic [1:0] sz_in, input logic sg,
                              input logic [31:0] a, input logic [31:0] wd, input int acc);
    logic [1:0]  sz;
    logic [1:0]  off;
    bit          mis;
    int          nb, shift, widx;
    logic [31:0] mask, v, nw;
    sz   = sz_in;
    off  = a[1:0];
    widx = int'(a[AW+1:2]);
`ifdef LSU_MISALIGN_TRAP_EN
    mis = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && off != 2'd0);
`else
    mis = 1'b0;
    if (sz == 2'd3) sz = 2'd2;
    if (sz == 2'd1) off[0] = 1'b0;
    if (sz == 2'd2) off = 2'd0;
`endif
    nb    = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    mask  = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 32'd1);
    shift = 8 * int'(off);
    if (mis) begin
      rq.push_back('{acc, acc + 1, 1'b0, 0, 32'd0, 1'b1});
    end else if (!we) begin
      v = (ref_mem[widx] >> shift) & mask;
      if (sg && nb < 4 && v[8 * nb - 1]) v = v | ~mask;
      rq.push_back('{acc, acc + 2, 1'b1, widx, v, 1'b0});
    end else begin
      nw = (ref_mem[widx] & ~(mask << shift)) | ((wd & mask) << shift);
      ref_mem[widx] = nw;
      wq.push_back('{acc + ((nb == 4) ? 1 : 2), widx, nw});
      rq.push_back('{acc, acc + ((nb == 4) ? 2 : 3), (nb != 4), widx, 32'd0, 1'b0});
    end
  endtask

  // Presents a request from a falling edge and holds it until accepted; returns the accept cycle.
  task automatic issue(input logic we, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd, output int acc);
    int n;
    n = 0;
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = we;
    req_size   = sz;
    req_signed = sg;
    req_addr   = a;
    req_wdata  = wd;
    while (!req_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      chk("accept_timeout", 32'd0, 32'd1);
      req_valid = 1'b0;
      acc = -1;
    end else begin
      acc = cyc;
      model_accept(we, sz, sg, a, wd, acc);
    end
  endtask

  task automatic wait_rsp(output int at, output logic [31:0] rd, output logic mis);
    int n;
    bit got;
    n = 0; got = 1'b0; at = -1; rd = '0; mis = 1'b0;
    while (!got && n < 12) begin
      @(posedge clk); #1;
      req_valid = 1'b0;
      n++;
      if (rsp_valid) begin
        got = 1'b1;
        at  = cyc;
        rd  = rsp_rdata;
        mis = rsp_misalign;
      end
    end
    if (!got) chk("rsp_timeout", 32'd0, 32'd1);
  endtask

  // Cycle-by-cycle comparison of the DUT against the model's queues.
  always begin : compare
    bit exp_rd, exp_wr, exp_rsp;
    @(posedge clk); #1;
    if (!rst) begin
      chk("req_ready", 32'(req_ready), 32'(rq.size() == 0));
      exp_rd = rq.size() > 0 && rq[0].rd && cyc == rq[0].acc + 1;
      chk("mem_read", 32'(mem_read), 32'(exp_rd));
      if (exp_rd) chk("mem_raddr", 32'(mem_raddr), rq[0].widx);
      exp_wr = wq.size() > 0 && cyc == wq[0].due;
      chk("mem_write", 32'(mem_write), 32'(exp_wr));
      if (exp_wr) begin
        chk("mem_waddr", 32'(mem_waddr), wq[0].widx);
        chk("mem_wdata", mem_wdata, wq[0].wdata);
        void'(wq.pop_front());
      end
      exp_rsp = rq.size() > 0 && cyc == rq[0].due;
      chk("rsp_valid", 32'(rsp_valid), 32'(exp_rsp));
      if (exp_rsp) begin
        chk("rsp_rdata", rsp_rdata, rq[0].rdata);
        chk("rsp_misalign", 32'(rsp_misalign), 32'(rq[0].mis));
        void'(rq.pop_front());
      end
      if (wq.size() > 0 && cyc > wq[0].due) void'(wq.pop_front());
      if (rq.size() > 0 && cyc > rq[0].due) void'(rq.pop_front());
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int          acc, acc1, acc2, acc3, at;
    logic [31:0] rd, saved;
    logic        mis;

    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = '0;
    req_signed = 1'b0; req_addr = '0; req_wdata = '0;
    for (int i = 0; i < (1 << AW); i++) begin
      mem[i]     = $urandom;
      ref_mem[i] = mem[i];
    end
    mem[4] = 32'h8899_AABB; ref_mem[4] = 32'h8899_AABB;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_misalign", 32'(rsp_misalign), 32'd0);
    chk("rst_mem_read", 32'(mem_read), 32'd0);
    chk("rst_mem_write", 32'(mem_write), 32'd0);
    chk("rst_mem_raddr", 32'(mem_raddr), 32'd0);
    chk("rst_mem_waddr", 32'(mem_waddr), 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Loads from word 4 = 0x8899AABB.
    issue(1'b0, 2'd0, 1'b1, 32'h13, 32'd0, acc);
    wait_rsp(at, rd, mis);
    chk("lb_rdata", rd, 32'hFFFF_FF88);
    chk("lb_latency", at - acc, 32'd2);
    issue(1'b0, 2'd0, 1'b0, 32'h13, 32'd0, acc);
    wait_rsp(at, rd, mis);
    chk("lbu_rdata", rd, 32'h0000_0088);
    issue(1'b0, 2'd1, 1'b0, 32'h10, 32'd0, acc);
    wait_rsp(at, rd, mis);
    chk("lhu_rdata", rd, 32'h0000_AABB);

    // Halfword store into the upper lane of word 4.
    issue(1'b1, 2'd1, 1'b0, 32'h12, 32'h0000_1234, acc);
    wait_rsp(at, rd, mis);
    chk("sh_latency", at - acc, 32'd3);
    chk("sh_rdata", rd, 32'd0);
    chk("sh_wr_cycle", last_wr_cyc - acc, 32'd2);
    chk("sh_waddr", last_wr_addr, 32'd4);
    chk("sh_mem", mem[4], 32'h1234_AABB);

    // Word store then load back.
    issue(1'b1, 2'd2, 1'b0, 32'h20, 32'hDEAD_BEEF, acc);
    wait_rsp(at, rd, mis);
    chk("sw_wr_cycle", last_wr_cyc - acc, 32'd1);
    chk("sw_waddr", last_wr_addr, 32'd8);
    chk("sw_latency", at - acc, 32'd2);
    issue(1'b0, 2'd2, 1'b0, 32'h20, 32'd0, acc);
    wait_rsp(at, rd, mis);
    chk("lw_rdata", rd, 32'hDEAD_BEEF);

    // Misaligned halfword load.
    issue(1'b0, 2'd1, 1'b1, 32'h11, 32'd0, acc);
    wait_rsp(at, rd, mis);
`ifdef LSU_MISALIGN_TRAP_EN
    chk("lh_mis_latency", at - acc, 32'd1);
    chk("lh_mis_flag", 32'(mis), 32'd1);
    chk("lh_mis_rdata", rd, 32'd0);
`else
    chk("lh_trunc_latency", at - acc, 32'd2);
    chk("lh_trunc_flag", 32'(mis), 32'd0);
    chk("lh_trunc_rdata", rd, 32'hFFFF_AABB);
`endif

    // Reset during the READ of a byte store aborts it.
    saved = ref_mem[4];
    issue(1'b1, 2'd0, 1'b0, 32'h10, 32'h55, acc);
    @(negedge clk);
    rst = 1'b1;
    req_valid = 1'b0;
    rq.delete();
    wq.delete();
    ref_mem[4] = saved;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("ready_after_rst", 32'(req_ready), 32'd1);
    repeat (4) @(posedge clk);
    #1;
    chk("sb_abort_mem", mem[4], 32'h1234_AABB);

    // req_valid held across three back-to-back loads.
    issue(1'b0, 2'd2, 1'b0, 32'h20, 32'd0, acc1);
    issue(1'b0, 2'd2, 1'b0, 32'h20, 32'd0, acc2);
    issue(1'b0, 2'd2, 1'b0, 32'h20, 32'd0, acc3);
    wait_rsp(at, rd, mis);
    chk("b2b_gap1", acc2 - acc1, 32'd3);
    chk("b2b_gap2", acc3 - acc2, 32'd3);
    chk("b2b_rdata", rd, 32'hDEAD_BEEF);

    // Randomized traffic over a small window of words with aliased upper address bits.
    for (int unsigned k = 0; k < 400; k++) begin
      if ($urandom_range(3) == 0) begin
        @(negedge clk);
        req_valid = 1'b0;
        repeat ($urandom_range(2)) @(negedge clk);
      end
      issue(1'($urandom_range(1)), 2'($urandom_range(3)), 1'($urandom_range(1)),
            $urandom & 32'hFFFF_F03F, $urandom, acc);
    end
    @(negedge clk);
    req_valid = 1'b0;
    repeat (8) @(negedge clk);
    chk("rsp_queue_drained", rq.size(), 32'd0);
    chk("wr_queue_drained", wq.size(), 32'd0);
    for (int i = 0; i < 16; i++) chk("mem_final", mem[i], ref_mem[i]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
